data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 108 ++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Doubleword data memory with a fixed-latency request/response handshake.
// A request is accepted in IDLE, waits LATENCY cycles, then yields a one-cycle Valid.
module data_mem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  output logic        Ready,
  output logic        Valid,
  output logic [63:0] ReadData,
  output logic        AddrErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          we_reg;
  logic [63:0]   addr_reg;
  logic [63:0]   wdata_reg;
  logic          err_reg;
  logic [63:0]   read_data_reg;
  logic [63:0]   word_rd [DEPTH];

  logic          accept;
  logic          access;
  logic          illegal;
  logic [AW-1:0] idx;

  assign accept  = (state_reg == IDLE) && Req;
  assign access  = (state_reg == WAIT) && (cnt_reg == '0);
  assign idx     = addr_reg[AW+2:3];
  assign illegal = (addr_reg[2:0] != 3'b000) || (|addr_reg[63:AW+3]);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (Req) begin
        state_next = WAIT;
        cnt_next   = CNT_INIT;
      end
      WAIT: begin
        if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
        else               state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      read_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= MemWrite;
        addr_reg  <= Address;
        wdata_reg <= WriteData;
      end
      if (access) begin
        err_reg <= illegal;
        // Stores leave ReadData untouched; errors clear it.
        if (illegal)      read_data_reg <= '0;
        else if (!we_reg) read_data_reg <= word_rd[idx];
      end
    end
  end

  // Each word is its own register so the whole array clears on reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [63:0] word_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          word_reg <= '0;
        else if (access && !illegal && we_reg && (idx == AW'(gi)))
          word_reg <= wdata_reg;
      end
      assign word_rd[gi] = word_reg;
    end
  endgenerate

  assign Ready    = (state_reg == IDLE);
  assign Valid    = (state_reg == RESP);
  assign AddrErr  = (state_reg == RESP) && err_reg;
  assign ReadData = read_data_reg;

endmodule
